npc_predictor: RTL and testbench

NPC_PREDICTOR -- requirements
Module: npc_predictor

---
 rtl/npc_predictor_if.sv | 28 ++
 rtl/npc_predictor.sv | 130 +++++++++++++
 tb/tb_npc_predictor.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_predictor_if.sv
// Fetch-side bus of the next-PC predictor: branch/exception redirects in,
// fetch address and prediction out.
interface npc_predictor_if;
    logic        fs_allowin;
    logic        br_valid;
    logic [31:0] br_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        br_pred_taken;
    logic [31:0] br_pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    modport master (
        output fs_allowin, br_valid, br_pc, br_taken, br_target, br_pred_taken,
               br_pred_target, ex_valid, ex_pc,
        input  pc, pred_taken, pred_target
    );

    modport slave (
        input  fs_allowin, br_valid, br_pc, br_taken, br_target, br_pred_taken,
               br_pred_target, ex_valid, ex_pc,
        output pc, pred_taken, pred_target
    );
endinterface

// File: rtl/npc_predictor.sv
// Next-PC generator with a direct-mapped branch target buffer and 2-bit counters.
// Predicted-taken branches fetch their delay slot before jumping to the target.
module npc_predictor #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter int unsigned IDX_W    = 6
) (
    input  logic           clk,
    input  logic           resetn,
    npc_predictor_if.slave bus
);
    localparam int Entries = 1 << IDX_W;
    localparam int TagW    = 30 - int'(IDX_W);

    localparam logic [0:0] StNormal = 1'b0;
    localparam logic [0:0] StSlot   = 1'b1;

    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [0:0]  state_q, state_d;

    logic            valid_q  [Entries];
    logic            valid_d  [Entries];
    logic [TagW-1:0] tag_q    [Entries];
    logic [TagW-1:0] tag_d    [Entries];
    logic [29:0]     target_q [Entries];
    logic [29:0]     target_d [Entries];
    logic [1:0]      cnt_q    [Entries];
    logic [1:0]      cnt_d    [Entries];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_hit;
    logic             wr_hit;
    logic             mispredict;

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    assign rd_idx = pc_q[IDX_W+1:2];
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == pc_q[31:IDX_W+2]);

    assign bus.pc          = pc_q;
    assign bus.pred_taken  = rd_hit && cnt_q[rd_idx][1];
    assign bus.pred_target = {target_q[rd_idx], 2'b00};

    assign wr_idx = bus.br_pc[IDX_W+1:2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == bus.br_pc[31:IDX_W+2]);

    assign mispredict = bus.br_valid &&
                        ((bus.br_pred_taken != bus.br_taken) ||
                         (bus.br_taken && bus.br_pred_taken &&
                          (bus.br_pred_target != bus.br_target)));

    always_comb begin
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        state_d = state_q;
        if (bus.ex_valid) begin
            pc_d    = bus.ex_pc;
            state_d = StNormal;
        end else if (mispredict) begin
            pc_d    = bus.br_taken ? bus.br_target : bus.br_pc + 32'd8;
            state_d = StNormal;
        end else if (bus.fs_allowin) begin
            case (state_q)
                StSlot: begin
                    // The delay-slot lookup is deliberately ignored here.
                    pc_d    = tgt_q;
                    state_d = StNormal;
                end
                default: begin
                    pc_d = pc_q + 32'd4;
                    if (bus.pred_taken) begin
                        tgt_d   = bus.pred_target;
                        state_d = StSlot;
                    end
                end
            endcase
        end
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (bus.br_valid) begin
            if (wr_hit) begin
                if (bus.br_taken) begin
                    cnt_d[wr_idx]    = (cnt_q[wr_idx] == 2'b11) ? 2'b11 : cnt_q[wr_idx] + 2'd1;
                    target_d[wr_idx] = bus.br_target[31:2];
                end else begin
                    cnt_d[wr_idx]    = (cnt_q[wr_idx] == 2'b00) ? 2'b00 : cnt_q[wr_idx] - 2'd1;
                end
            end else if (bus.br_taken) begin
                // Allocation on a taken miss evicts whatever aliased into this slot.
                valid_d[wr_idx]  = 1'b1;
                tag_d[wr_idx]    = bus.br_pc[31:IDX_W+2];
                target_d[wr_idx] = bus.br_target[31:2];
                cnt_d[wr_idx]    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q    <= RESET_PC;
            tgt_q   <= 32'd0;
            state_q <= StNormal;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < Entries; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_npc_predictor.sv
// Scenario bench for npc_predictor: each step's expected fetch state is queued
// when the step is driven and compared one cycle later.
module tb_npc_predictor;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    npc_predictor_if bus ();

    npc_predictor #(
        .RESET_PC(RESET_PC),
        .IDX_W   (6)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fs;
        logic        brv;
        logic [31:0] bpc;
        logic        btk;
        logic [31:0] btg;
        logic        bpt;
        logic [31:0] bptg;
        logic        exv;
        logic [31:0] expc;
        logic [31:0] epc;
        logic        ept;
        logic        chk_tg;
        logic [31:0] etg;
    } step_t;

    step_t exp_q[$];

    function automatic step_t s_idle(logic fs, logic [31:0] epc, logic ept);
        step_t s;
        s     = '0;
        s.fs  = fs;
        s.epc = epc;
        s.ept = ept;
        return s;
    endfunction

    function automatic step_t s_br(logic fs, logic [31:0] bpc, logic btk, logic [31:0] btg,
                                   logic bpt, logic [31:0] bptg, logic [31:0] epc, logic ept);
        step_t s;
        s      = s_idle(fs, epc, ept);
        s.brv  = 1'b1;
        s.bpc  = bpc;
        s.btk  = btk;
        s.btg  = btg;
        s.bpt  = bpt;
        s.bptg = bptg;
        return s;
    endfunction

    function automatic step_t s_ex(logic [31:0] expc, logic [31:0] epc, logic ept);
        step_t s;
        s      = s_idle(1'b0, epc, ept);
        s.exv  = 1'b1;
        s.expc = expc;
        return s;
    endfunction

    function automatic step_t s_tg(step_t s_in, logic [31:0] etg);
        step_t s;
        s        = s_in;
        s.chk_tg = 1'b1;
        s.etg    = etg;
        return s;
    endfunction

    task automatic set_idle();
        bus.fs_allowin     = 1'b0;
        bus.br_valid       = 1'b0;
        bus.br_pc          = '0;
        bus.br_taken       = 1'b0;
        bus.br_target      = '0;
        bus.br_pred_taken  = 1'b0;
        bus.br_pred_target = '0;
        bus.ex_valid       = 1'b0;
        bus.ex_pc          = '0;
    endtask

    task automatic drive(step_t s);
        bus.fs_allowin     = s.fs;
        bus.br_valid       = s.brv;
        bus.br_pc          = s.bpc;
        bus.br_taken       = s.btk;
        bus.br_target      = s.btg;
        bus.br_pred_taken  = s.bpt;
        bus.br_pred_target = s.bptg;
        bus.ex_valid       = s.exv;
        bus.ex_pc          = s.expc;
        exp_q.push_back(s);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.pc !== RESET_PC || bus.pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: pc=%h pred_taken=%b, expected pc=%h pred_taken=0",
                     bus.pc, bus.pred_taken, RESET_PC);
        end
        resetn = 1'b1;
    endtask

    task automatic test_sequential();
        step_t seq[$];
        step_t e;
        seq.push_back(s_idle(1'b0, RESET_PC, 1'b0));
        for (int i = 1; i <= 3; i++) seq.push_back(s_idle(1'b1, RESET_PC + 32'(4 * i), 1'b0));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.pc !== e.epc || bus.pred_taken !== e.ept) begin
                n_fail++;
                $display("FAIL sequential step %0d: pc=%h pt=%b, expected pc=%h pt=%b",
                         i, bus.pc, bus.pred_taken, e.epc, e.ept);
            end
        end
    endtask

    task automatic test_train();
        step_t seq[$];
        step_t e;
        seq.push_back(s_br(1'b0, 32'hbfc00010, 1'b1, 32'hbfc00100, 1'b1, 32'hbfc00100,
                           32'hbfc0000c, 1'b0));
        seq.push_back(s_br(1'b0, 32'hbfc00010, 1'b1, 32'hbfc00100, 1'b1, 32'hbfc00100,
                           32'hbfc0000c, 1'b0));
        seq.push_back(s_tg(s_idle(1'b1, 32'hbfc00010, 1'b1), 32'hbfc00100));
        seq.push_back(s_idle(1'b1, 32'hbfc00014, 1'b0));
        seq.push_back(s_idle(1'b1, 32'hbfc00100, 1'b0));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.pc !== e.epc || bus.pred_taken !== e.ept ||
                (e.chk_tg && bus.pred_target !== e.etg)) begin
                n_fail++;
                $display("FAIL train step %0d: pc=%h pt=%b tgt=%h, expected pc=%h pt=%b tgt=%h",
                         i, bus.pc, bus.pred_taken, bus.pred_target, e.epc, e.ept, e.etg);
            end
        end
    endtask

    task automatic test_mispredict();
        step_t seq[$];
        step_t e;
        // Two not-taken resolves: 3->2 still predicts taken, 2->1 no longer does.
        seq.push_back(s_br(1'b0, 32'hbfc00010, 1'b0, 32'h0, 1'b1, 32'hbfc00100,
                           32'hbfc00018, 1'b0));
        seq.push_back(s_ex(32'hbfc00010, 32'hbfc00010, 1'b1));
        seq.push_back(s_br(1'b0, 32'hbfc00010, 1'b0, 32'h0, 1'b1, 32'hbfc00100,
                           32'hbfc00018, 1'b0));
        seq.push_back(s_ex(32'hbfc00010, 32'hbfc00010, 1'b0));
        seq.push_back(s_idle(1'b1, 32'hbfc00014, 1'b0));
        seq.push_back(s_idle(1'b1, 32'hbfc00018, 1'b0));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.pc !== e.epc || bus.pred_taken !== e.ept) begin
                n_fail++;
                $display("FAIL mispredict step %0d: pc=%h pt=%b, expected pc=%h pt=%b",
                         i, bus.pc, bus.pred_taken, e.epc, e.ept);
            end
        end
    endtask

    task automatic test_exception();
        step_t seq[$];
        step_t e;
        step_t s;
        s      = s_br(1'b1, 32'hbfc00010, 1'b1, 32'hbfc00100, 1'b0, 32'h0, 32'hbfc00380, 1'b0);
        s.exv  = 1'b1;
        s.expc = 32'hbfc00380;
        seq.push_back(s);
        seq.push_back(s_tg(s_ex(32'hbfc00010, 32'hbfc00010, 1'b1), 32'hbfc00100));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.pc !== e.epc || bus.pred_taken !== e.ept ||
                (e.chk_tg && bus.pred_target !== e.etg)) begin
                n_fail++;
                $display("FAIL exception step %0d: pc=%h pt=%b tgt=%h, expected pc=%h pt=%b tgt=%h",
                         i, bus.pc, bus.pred_taken, bus.pred_target, e.epc, e.ept, e.etg);
            end
        end
    endtask

    task automatic test_slot_hold();
        step_t seq[$];
        step_t e;
        seq.push_back(s_idle(1'b1, 32'hbfc00014, 1'b0));
        repeat (4) seq.push_back(s_idle(1'b0, 32'hbfc00014, 1'b0));
        seq.push_back(s_idle(1'b1, 32'hbfc00100, 1'b0));
        seq.push_back(s_idle(1'b1, 32'hbfc00104, 1'b0));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.pc !== e.epc || bus.pred_taken !== e.ept) begin
                n_fail++;
                $display("FAIL slot_hold step %0d: pc=%h pt=%b, expected pc=%h pt=%b",
                         i, bus.pc, bus.pred_taken, e.epc, e.ept);
            end
        end
    endtask

    task automatic test_reset_in_slot();
        step_t seq[$];
        step_t post[$];
        step_t e;
        seq.push_back(s_ex(32'hbfc00010, 32'hbfc00010, 1'b1));
        seq.push_back(s_idle(1'b1, 32'hbfc00014, 1'b0));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.pc !== e.epc || bus.pred_taken !== e.ept) begin
                n_fail++;
                $display("FAIL reset_slot step %0d: pc=%h pt=%b, expected pc=%h pt=%b",
                         i, bus.pc, bus.pred_taken, e.epc, e.ept);
            end
        end
        set_idle();
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (bus.pc !== RESET_PC || bus.pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: pc=%h pt=%b, expected pc=%h pt=0",
                     bus.pc, bus.pred_taken, RESET_PC);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        // The pending slot target and the trained entry must both be gone.
        post.push_back(s_idle(1'b1, 32'hbfc00004, 1'b0));
        post.push_back(s_ex(32'hbfc00010, 32'hbfc00010, 1'b0));
        foreach (post[i]) begin
            drive(post[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.pc !== e.epc || bus.pred_taken !== e.ept) begin
                n_fail++;
                $display("FAIL after_reset step %0d: pc=%h pt=%b, expected pc=%h pt=%b",
                         i, bus.pc, bus.pred_taken, e.epc, e.ept);
            end
        end
    endtask

    task automatic test_alias();
        step_t seq[$];
        step_t e;
        seq.push_back(s_tg(s_br(1'b0, 32'hbfc00010, 1'b1, 32'hbfc00100, 1'b1, 32'hbfc00100,
                                32'hbfc00010, 1'b1), 32'hbfc00100));
        seq.push_back(s_br(1'b0, 32'hbfc00110, 1'b1, 32'hbfc00200, 1'b1, 32'hbfc00200,
                           32'hbfc00010, 1'b0));
        seq.push_back(s_tg(s_ex(32'hbfc00110, 32'hbfc00110, 1'b1), 32'hbfc00200));
        // Taken with a stale predicted target: redirect and retarget the entry.
        seq.push_back(s_br(1'b0, 32'hbfc00110, 1'b1, 32'hbfc00300, 1'b1, 32'hbfc00200,
                           32'hbfc00300, 1'b0));
        seq.push_back(s_tg(s_ex(32'hbfc00110, 32'hbfc00110, 1'b1), 32'hbfc00300));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.pc !== e.epc || bus.pred_taken !== e.ept ||
                (e.chk_tg && bus.pred_target !== e.etg)) begin
                n_fail++;
                $display("FAIL alias step %0d: pc=%h pt=%b tgt=%h, expected pc=%h pt=%b tgt=%h",
                         i, bus.pc, bus.pred_taken, bus.pred_target, e.epc, e.ept, e.etg);
            end
        end
    endtask

    task automatic test_wrap();
        step_t seq[$];
        step_t e;
        seq.push_back(s_ex(32'hfffffff8, 32'hfffffff8, 1'b0));
        seq.push_back(s_idle(1'b1, 32'hfffffffc, 1'b0));
        seq.push_back(s_idle(1'b1, 32'h00000000, 1'b0));
        seq.push_back(s_idle(1'b1, 32'h00000004, 1'b0));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.pc !== e.epc || bus.pred_taken !== e.ept) begin
                n_fail++;
                $display("FAIL wrap step %0d: pc=%h pt=%b, expected pc=%h pt=%b",
                         i, bus.pc, bus.pred_taken, e.epc, e.ept);
            end
        end
    endtask

    task automatic test_slot_ignore();
        step_t seq[$];
        step_t e;
        seq.push_back(s_br(1'b0, 32'hbfc00010, 1'b1, 32'hbfc00100, 1'b1, 32'hbfc00100,
                           32'h00000004, 1'b0));
        seq.push_back(s_br(1'b0, 32'hbfc00014, 1'b1, 32'hbfc00500, 1'b1, 32'hbfc00500,
                           32'h00000004, 1'b0));
        seq.push_back(s_ex(32'hbfc00010, 32'hbfc00010, 1'b1));
        seq.push_back(s_tg(s_idle(1'b1, 32'hbfc00014, 1'b1), 32'hbfc00500));
        seq.push_back(s_idle(1'b1, 32'hbfc00100, 1'b0));
        seq.push_back(s_idle(1'b1, 32'hbfc00104, 1'b0));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.pc !== e.epc || bus.pred_taken !== e.ept ||
                (e.chk_tg && bus.pred_target !== e.etg)) begin
                n_fail++;
                $display("FAIL slot_ignore step %0d: pc=%h pt=%b tgt=%h, expected pc=%h pt=%b tgt=%h",
                         i, bus.pc, bus.pred_taken, bus.pred_target, e.epc, e.ept, e.etg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_train();
        test_mispredict();
        test_exception();
        test_slot_hold();
        test_reset_in_slot();
        test_alias();
        test_wrap();
        test_slot_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
